// File: rtl/pc_seq_pkg.sv
// Shared constants for the 2-bit computer control sequencer: state encoding,
// default program counter width and wait counter width.
package pc_seq_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_EXEC  = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  localparam int PC_W_DEFAULT = 2;
  localparam int WAIT_W       = 4;

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// Program counter register: synchronous reset, parallel load, increment with
// natural wrap-around modulo 2^PC_W. Load has priority over increment.
module pc_reg
  import pc_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] q
);

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + PC_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the 2-bit computer: owns the PC, runs the
// Mem_Req/Mem_Ack fetch handshake and strobes Exec_En. Optional breakpoint
// logic is enabled with the macro PC_SEQ_BREAKPOINT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W     = PC_W_DEFAULT,
  parameter int MAX_WAIT = 3
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Run,
  input  logic            Step,
  input  logic            Jump,
  input  logic [PC_W-1:0] Jump_Addr,
  input  logic            Mem_Ack,
`ifdef PC_SEQ_BREAKPOINT_EN
  input  logic [PC_W-1:0] Bp_Addr,
  input  logic            Bp_Valid,
  output logic            Bp_Hit,
`endif
  output logic            Mem_Req,
  output logic [PC_W-1:0] PC,
  output logic            Exec_En,
  output logic            Busy,
  output logic            Fault
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [1:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              step_mode, step_nxt;
  logic              pc_load, pc_inc;
  logic              run_ok;

`ifdef PC_SEQ_BREAKPOINT_EN
  logic              bp_lock, bp_lock_nxt;
  logic              bp_hit_nxt;
  logic [PC_W-1:0]   next_pc;

  assign next_pc = Jump ? Jump_Addr : PC + PC_W'(1);
  // After a breakpoint, Run must be released once before free-run resumes.
  assign run_ok  = Run && !bp_lock;
`else
  assign run_ok  = Run;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    step_nxt  = step_mode;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
`ifdef PC_SEQ_BREAKPOINT_EN
    bp_lock_nxt = bp_lock;
    bp_hit_nxt  = 1'b0;
`endif

    case (state)
      S_IDLE: begin
`ifdef PC_SEQ_BREAKPOINT_EN
        if (bp_lock && !Run) bp_lock_nxt = 1'b0;
`endif
        if (run_ok) begin
          state_nxt = S_FETCH;
          step_nxt  = 1'b0;
        end else if (Step) begin
          state_nxt = S_FETCH;
          step_nxt  = 1'b1;
        end
      end

      S_FETCH: begin
        // An ack on the last permitted wait cycle still wins over the fault.
        if (Mem_Ack) begin
          state_nxt = S_EXEC;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_FAULT;
          wait_nxt  = '0;
        end else begin
          wait_nxt  = wait_cnt + WAIT_W'(1);
        end
      end

      S_EXEC: begin
        pc_load = Jump;
        pc_inc  = !Jump;
        if (step_mode || !Run) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_FETCH;
        end
`ifdef PC_SEQ_BREAKPOINT_EN
        if (Bp_Valid && (next_pc == Bp_Addr)) begin
          state_nxt   = S_IDLE;
          bp_hit_nxt  = 1'b1;
          bp_lock_nxt = 1'b1;
        end
`endif
      end

      S_FAULT: begin
        state_nxt = S_FAULT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      step_mode <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      step_mode <= step_nxt;
    end
  end

`ifdef PC_SEQ_BREAKPOINT_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      bp_lock <= 1'b0;
      Bp_Hit  <= 1'b0;
    end else begin
      bp_lock <= bp_lock_nxt;
      Bp_Hit  <= bp_hit_nxt;
    end
  end
`endif

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (pc_load),
    .load_val (Jump_Addr),
    .inc      (pc_inc),
    .q        (PC)
  );

  assign Mem_Req = (state == S_FETCH);
  assign Exec_En = (state == S_EXEC);
  assign Busy    = (state == S_FETCH) || (state == S_EXEC);
  assign Fault   = (state == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the basic flows plus
// hand-written sequences for fault, late ack, mid-fetch reset and breakpoint.
module tb_pc_sequencer;

  localparam int PC_W = 2;

  logic            CLK;
  logic            Reset;
  logic            Run;
  logic            Step;
  logic            Jump;
  logic [PC_W-1:0] Jump_Addr;
  logic            Mem_Ack;
  logic            Mem_Req;
  logic [PC_W-1:0] PC;
  logic            Exec_En;
  logic            Busy;
  logic            Fault;
`ifdef PC_SEQ_BREAKPOINT_EN
  logic [PC_W-1:0] Bp_Addr;
  logic            Bp_Valid;
  logic            Bp_Hit;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(PC_W), .MAX_WAIT(3)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Run       (Run),
    .Step      (Step),
    .Jump      (Jump),
    .Jump_Addr (Jump_Addr),
    .Mem_Ack   (Mem_Ack),
`ifdef PC_SEQ_BREAKPOINT_EN
    .Bp_Addr   (Bp_Addr),
    .Bp_Valid  (Bp_Valid),
    .Bp_Hit    (Bp_Hit),
`endif
    .Mem_Req   (Mem_Req),
    .PC        (PC),
    .Exec_En   (Exec_En),
    .Busy      (Busy),
    .Fault     (Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       run;
    logic       step;
    logic       jump;
    logic [1:0] ja;
    logic       ack;
    logic [5:0] exp;   // {Mem_Req, Exec_En, Busy, Fault, PC}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {Mem_Req, Exec_En, Busy, Fault, PC};
  endfunction

  task automatic v(input logic rst, input logic run, input logic step, input logic jump,
                   input logic [1:0] ja, input logic ack,
                   input logic req, input logic ex, input logic bsy, input logic flt,
                   input logic [1:0] pc);
    vec_t t;
    t.rst = rst; t.run = run; t.step = step; t.jump = jump; t.ja = ja; t.ack = ack;
    t.exp = {req, ex, bsy, flt, pc};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic run, input logic step,
                       input logic jump, input logic [1:0] ja, input logic ack);
    Reset = rst; Run = run; Step = step; Jump = jump; Jump_Addr = ja; Mem_Ack = ack;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
`ifdef PC_SEQ_BREAKPOINT_EN
    Bp_Addr  = '0;
    Bp_Valid = 1'b0;
`endif
    drive(1, 0, 0, 0, 0, 0);

    //     rst run stp jmp ja ack | req ex bsy flt pc
    v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);   // reset held two cycles
    v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0);   // step pulse
    v(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0);   // ack one cycle after req
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);   // back to idle, PC=1
    v(0, 0, 0, 1, 3, 1,  0, 0, 0, 0, 1);   // jump/ack ignored in idle
    v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0);   // free-run, immediate ack
    v(0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 0);
    v(0, 1, 0, 0, 0, 1,  1, 0, 1, 0, 1);
    v(0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 1);
    v(0, 1, 0, 0, 0, 1,  1, 0, 1, 0, 2);
    v(0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 2);
    v(0, 1, 0, 0, 0, 1,  1, 0, 1, 0, 3);
    v(0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 3);
    v(0, 1, 0, 0, 0, 1,  1, 0, 1, 0, 0);   // wrap 3 -> 0
    v(0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 0);
    v(0, 1, 0, 1, 2, 0,  1, 0, 1, 0, 2);   // jump in EXEC at PC=0
    v(0, 1, 0, 1, 1, 0,  1, 0, 1, 0, 2);   // jump in FETCH ignored
    v(0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 2);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3);   // Run low in EXEC -> idle
    v(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 3);
    v(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 3);   // Run drop in FETCH: no abort
    v(0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 3);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    v(0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0);   // Run and Step: Run wins
    v(0, 1, 1, 0, 0, 1,  0, 1, 1, 0, 0);
    v(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 1);   // free-run continues
    v(0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 1);
    v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].step, vecs[i].jump, vecs[i].ja, vecs[i].ack);
      tick();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Missing ack: fault after three FETCH cycles, PC held, only Reset exits.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    check("fault_pre_pc", 32'(PC), 32'd1);
    drive(0, 1, 0, 0, 0, 0); tick();
    tick();
    tick();
    check("fault_fetch3", 32'(obs()), 32'({4'b1010, 2'd1}));
    tick();
    check("fault_enter", 32'(obs()), 32'({4'b0001, 2'd1}));
    drive(0, 0, 1, 0, 0, 1); tick();
    check("fault_ign_step", 32'(obs()), 32'({4'b0001, 2'd1}));
    drive(0, 1, 0, 1, 3, 1); tick();
    check("fault_ign_run", 32'(obs()), 32'({4'b0001, 2'd1}));
    drive(1, 0, 0, 0, 0, 0); tick();
    check("fault_reset", 32'(obs()), 32'({4'b0000, 2'd0}));

    // Ack on the final wait cycle wins; then reset in the following FETCH.
    drive(0, 1, 0, 0, 0, 0); tick();
    tick();
    tick();
    check("late_fetch3", 32'(obs()), 32'({4'b1010, 2'd0}));
    drive(0, 1, 0, 0, 0, 1); tick();
    check("late_ack_exec", 32'(obs()), 32'({4'b0110, 2'd0}));
    drive(0, 1, 0, 0, 0, 0); tick();
    check("late_refetch", 32'(obs()), 32'({4'b1010, 2'd1}));
    drive(1, 1, 0, 0, 0, 0); tick();
    check("midfetch_reset", 32'(obs()), 32'({4'b0000, 2'd0}));

`ifdef PC_SEQ_BREAKPOINT_EN
    // Breakpoint at PC=2 stops free-run until Run is released once.
    Bp_Addr = 2'd2; Bp_Valid = 1'b1;
    drive(0, 1, 0, 0, 0, 1); tick();
    check("bp_hit_idle0", 32'(Bp_Hit), 32'd0);
    tick(); tick(); tick();
    check("bp_exec_pc1", 32'(obs()), 32'({4'b0110, 2'd1}));
    tick();
    check("bp_stop", 32'(obs()), 32'({4'b0000, 2'd2}));
    check("bp_hit_pulse", 32'(Bp_Hit), 32'd1);
    tick();
    check("bp_hit_clear", 32'(Bp_Hit), 32'd0);
    check("bp_locked", 32'(obs()), 32'({4'b0000, 2'd2}));
    tick();
    check("bp_locked2", 32'(obs()), 32'({4'b0000, 2'd2}));
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1); tick();
    check("bp_resume", 32'(obs()), 32'({4'b1010, 2'd2}));
    tick(); tick();
    check("bp_resume_pc", 32'(obs()), 32'({4'b1010, 2'd3}));
    check("bp_no_hit", 32'(Bp_Hit), 32'd0);
    Bp_Valid = 1'b0;
`endif

    drive(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
